// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipe_ctrl_pkg
// Brief  : Shared state encoding and register constants for pipeline_ctrl.
// Rev    : 1.0
// ============================================================================
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } ctrl_state_t;

   localparam logic [4:0] REG_X0 = 5'd0;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module : hazard_detect
// Brief  : Combinational load-use comparator between the ID and EX stages.
// Rev    : 1.0
// ============================================================================
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_uses_rs1,
   input  logic       id_uses_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   output logic       load_use
);

   // x0 is hard-wired to zero, so a load targeting it never creates a dependency
   assign load_use = ex_mem_read && (ex_rd != REG_X0) &&
                     ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                      (id_uses_rs2 && (id_rs2 == ex_rd)));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Stall/flush controller with data-memory wait FSM and watchdog.
//          Optional counters enabled by PIPE_CTRL_PERF_EN.
// Rev    : 1.0
// ============================================================================
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)(
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  id_rs1,
   input  logic [4:0]  id_rs2,
   input  logic        id_uses_rs1,
   input  logic        id_uses_rs2,
   input  logic [4:0]  ex_rd,
   input  logic        ex_mem_read,
   input  logic        ex_branch_taken,
   input  logic        mem_req,
   input  logic        mem_ready,
   output logic        mem_valid,
   output logic        pc_en,
   output logic        if_id_en,
   output logic        id_ex_en,
   output logic        ex_mem_en,
   output logic        if_id_flush,
   output logic        id_ex_flush,
   output logic        mem_wb_flush,
`ifdef PIPE_CTRL_PERF_EN
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_events,
`endif
   output logic        halted
);

   localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   ctrl_state_t      state, state_nxt;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
   logic             load_use;
   logic             mem_stall;
   logic             req_valid;

   hazard_detect u_hazard_detect (
      .id_rs1      (id_rs1),
      .id_rs2      (id_rs2),
      .id_uses_rs1 (id_uses_rs1),
      .id_uses_rs2 (id_uses_rs2),
      .ex_rd       (ex_rd),
      .ex_mem_read (ex_mem_read),
      .load_use    (load_use)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= RUN;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      mem_stall    = 1'b0;
      req_valid    = 1'b0;
      case (state)
         RUN: begin
            req_valid = mem_req;
            mem_stall = mem_req && !mem_ready;
            if (mem_stall) begin
               state_nxt    = MEM_WAIT;
               wait_cnt_nxt = CNT_W'(1);
            end
         end
         MEM_WAIT: begin
            req_valid = 1'b1;
            mem_stall = !mem_ready;
            if (mem_ready) begin
               state_nxt    = RUN;
               wait_cnt_nxt = '0;
            end else if (wait_cnt == CNT_MAX) begin
               state_nxt = HALT;
            end else begin
               wait_cnt_nxt = wait_cnt + CNT_W'(1);
            end
         end
         HALT:    state_nxt = HALT;
         default: state_nxt = RUN;
      endcase
   end

   // Output priority: reset > HALT > memory stall > branch squash > load-use
   always_comb begin
      mem_valid    = req_valid;
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      mem_wb_flush = 1'b0;
      if (reset) begin
         mem_valid    = 1'b0;
         {pc_en, if_id_en, id_ex_en, ex_mem_en}  = 4'b0000;
         {if_id_flush, id_ex_flush, mem_wb_flush} = 3'b111;
      end else if (state == HALT) begin
         mem_valid = 1'b0;
         {pc_en, if_id_en, id_ex_en, ex_mem_en}  = 4'b0000;
      end else if (mem_stall) begin
         {pc_en, if_id_en, id_ex_en, ex_mem_en}  = 4'b0000;
         mem_wb_flush = 1'b1;
      end else if (ex_branch_taken) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (load_use) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign halted = (state == HALT);

`ifdef PIPE_CTRL_PERF_EN
   logic active;
   assign active = (state != HALT);

   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else if (active) begin
         if (mem_stall || (!ex_branch_taken && load_use))
            stall_cycles <= stall_cycles + 32'd1;
         if (!mem_stall && ex_branch_taken)
            flush_events <= flush_events + 32'd1;
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipeline_ctrl
// Brief  : Scoreboard bench for pipeline_ctrl against a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_pipeline_ctrl;

   localparam int TMO = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic        mem_req, mem_ready;
   logic        mem_valid, pc_en, if_id_en, id_ex_en, ex_mem_en;
   logic        if_id_flush, id_ex_flush, mem_wb_flush, halted;
   logic [31:0] stall_cycles, flush_events;

   always #5 clock = ~clock;

   pipeline_ctrl #(.MEM_TIMEOUT(TMO)) dut (
      .clock           (clock),
      .reset           (reset),
      .id_rs1          (id_rs1),
      .id_rs2          (id_rs2),
      .id_uses_rs1     (id_uses_rs1),
      .id_uses_rs2     (id_uses_rs2),
      .ex_rd           (ex_rd),
      .ex_mem_read     (ex_mem_read),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .mem_valid       (mem_valid),
      .pc_en           (pc_en),
      .if_id_en        (if_id_en),
      .id_ex_en        (id_ex_en),
      .ex_mem_en       (ex_mem_en),
      .if_id_flush     (if_id_flush),
      .id_ex_flush     (id_ex_flush),
      .mem_wb_flush    (mem_wb_flush),
`ifdef PIPE_CTRL_PERF_EN
      .stall_cycles    (stall_cycles),
      .flush_events    (flush_events),
`endif
      .halted          (halted)
   );

`ifndef PIPE_CTRL_PERF_EN
   assign stall_cycles = '0;
   assign flush_events = '0;
`endif

   // ctl = {mem_valid, pc,if_id,id_ex,ex_mem enables, if_id,id_ex,mem_wb flushes, halted}
   typedef struct packed {
      logic [8:0]  ctl;
      logic [31:0] sc;
      logic [31:0] fe;
      int          tag;
   } exp_t;

   exp_t q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc_tag     = 0;

   // Reference model: consecutive unanswered request cycles and a sticky halt flag
   bit          m_halted, m_waiting;
   int          m_miss;
   logic [31:0] m_sc, m_fe;

   task automatic clear_inputs();
      reset = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_rd = 0; ex_mem_read = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   task automatic cycle();
      exp_t e;
      bit   lu, act, stall;
      lu = ex_mem_read && (ex_rd != 0) &&
           ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      act   = m_waiting || mem_req;
      stall = act && !mem_ready;
      e.sc  = m_sc;
      e.fe  = m_fe;
      e.tag = cyc_tag;
      if (reset)                e.ctl = {1'b0, 4'b0000, 3'b111, m_halted};
      else if (m_halted)        e.ctl = {1'b0, 4'b0000, 3'b000, 1'b1};
      else if (stall)           e.ctl = {1'b1, 4'b0000, 3'b001, 1'b0};
      else if (ex_branch_taken) e.ctl = {act,  4'b1111, 3'b110, 1'b0};
      else if (lu)              e.ctl = {act,  4'b0011, 3'b010, 1'b0};
      else                      e.ctl = {act,  4'b1111, 3'b000, 1'b0};
      q.push_back(e);
      if (reset) begin
         m_halted = 0; m_waiting = 0; m_miss = 0; m_sc = 0; m_fe = 0;
      end else if (!m_halted) begin
         if (stall)                m_sc = m_sc + 1;
         else if (ex_branch_taken) m_fe = m_fe + 1;
         else if (lu)              m_sc = m_sc + 1;
         if (act && mem_ready) begin
            m_waiting = 0; m_miss = 0;
         end else if (stall) begin
            m_waiting = 1; m_miss = m_miss + 1;
            if (m_miss == TMO + 1) m_halted = 1;
         end
      end
      cyc_tag = cyc_tag + 1;
      @(posedge clock);
      #1;
   endtask

   task automatic mem_access(input int lows, input bit br);
      mem_req = 1; ex_branch_taken = br;
      for (int i = 0; i < lows; i++) begin mem_ready = 0; cycle(); end
      mem_ready = 1; cycle();
      clear_inputs();
   endtask

   // Monitor: compares whatever the DUT presents against the oldest expectation
   initial begin
      exp_t e;
      logic [8:0] act_ctl;
      forever begin
         @(negedge clock);
         if (q.size() > 0) begin
            e = q.pop_front();
            act_ctl = {mem_valid, pc_en, if_id_en, id_ex_en, ex_mem_en,
                       if_id_flush, id_ex_flush, mem_wb_flush, halted};
            vectors++;
            if (act_ctl !== e.ctl) begin
               miscompares++;
               $display("FAIL ctl cycle %0d: got %b expected %b", e.tag, act_ctl, e.ctl);
            end
`ifdef PIPE_CTRL_PERF_EN
            vectors++;
            if (stall_cycles !== e.sc || flush_events !== e.fe) begin
               miscompares++;
               $display("FAIL perf cycle %0d: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                        e.tag, stall_cycles, flush_events, e.sc, e.fe);
            end
`endif
         end
      end
   end

   initial begin
      clear_inputs();
      reset = 1;
      repeat (2) @(posedge clock);
      #1;
      m_halted = 0; m_waiting = 0; m_miss = 0; m_sc = 0; m_fe = 0;
      reset = 1; cycle();
      clear_inputs();

      // load x5 in EX, add x6,x5,x7 in ID, then the same against x0
      ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs2 = 7; id_uses_rs1 = 1; id_uses_rs2 = 1;
      cycle();
      ex_mem_read = 0; cycle();
      ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; cycle();
      ex_rd = 7; id_rs1 = 3; cycle();
      ex_branch_taken = 1; cycle();
      clear_inputs();

      mem_access(0, 0);   // zero-wait access
      mem_access(3, 0);   // three stall cycles
      mem_access(2, 1);   // branch held through the wait
      mem_access(TMO, 0); // ready on the last tolerated cycle

      // watchdog fires, halt ignores ready, reset recovers
      mem_req = 1;
      for (int i = 0; i < TMO + 1; i++) cycle();
      mem_ready = 1; ex_branch_taken = 1; cycle(); cycle();
      reset = 1; cycle();
      clear_inputs(); cycle();

      // counter scenario: 2 load-use + 3 mem-wait + 1 branch, then reset mid-wait
      ex_mem_read = 1; ex_rd = 9; id_rs2 = 9; id_uses_rs2 = 1; cycle(); cycle();
      clear_inputs();
      mem_access(3, 0);
      ex_branch_taken = 1; cycle();
      clear_inputs(); cycle();
      mem_req = 1; cycle(); cycle();
      reset = 1; cycle();
      clear_inputs(); cycle();

      for (int n = 0; n < 3000; n++) begin
         reset           = ($urandom_range(0, 79) == 0);
         id_rs1          = 5'($urandom_range(0, 3));
         id_rs2          = 5'($urandom_range(0, 3));
         id_uses_rs1     = 1'($urandom);
         id_uses_rs2     = 1'($urandom);
         ex_rd           = 5'($urandom_range(0, 3));
         ex_mem_read     = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         mem_req         = 1'($urandom);
         mem_ready       = ($urandom_range(0, 2) != 0);
         cycle();
      end
      clear_inputs();

      repeat (3) @(posedge clock);
      vectors++;
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
